// File: rtl/bus_pkg.sv
// Shared system-bus definitions: response codes, master FSM states and HADDR field layout.
// Used by the bus master, the split-capable slaves and the arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_SPLIT_WAIT
  } state_e;

  localparam int HADDR_PHASE_BIT = 15;
  localparam int HADDR_SLV_LSB   = 13;
  localparam int HADDR_WR_BIT    = 12;
  localparam int HADDR_ADDR_LSB  = 0;

  localparam logic [1:0] NO_MASTER = 2'b00;

  function automatic logic [15:0] make_haddr(input logic        phase,
                                             input logic [1:0]  slv,
                                             input logic        wr,
                                             input logic [11:0] addr);
    logic [15:0] a;
    a                           = '0;
    a[HADDR_PHASE_BIT]          = phase;
    a[HADDR_SLV_LSB +: 2]       = slv;
    a[HADDR_WR_BIT]             = wr;
    a[HADDR_ADDR_LSB +: 12]     = addr;
    return a;
  endfunction

endpackage

// File: rtl/bus_master_split.sv
// Single-command bus initiator with arbitration, wait states, RETRY and SPLIT handling.
// Optional DATA-phase watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_master_split
  import bus_pkg::*;
#(
  parameter logic [1:0] MASTER_ID      = 2'b01,
  parameter int         MAX_RETRY      = 4,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_slv,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_lock,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        breq,
  input  logic        bgnt,
  output logic [15:0] haddr,
  output logic [31:0] hwdata,
  output logic [1:0]  hmas,
  output logic        mlock,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [1:0]  hsplit
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  if (MASTER_ID == NO_MASTER || MAX_RETRY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("bus_master_split: illegal MASTER_ID, MAX_RETRY or TIMEOUT_CYCLES");
  end

  state_e         state;
  logic           c_write;
  logic [1:0]     c_slv;
  logic [11:0]    c_addr;
  logic [31:0]    c_wdata;
  logic           c_lock;
  logic [RW-1:0]  retry_cnt;
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]  tmo_cnt;
`endif

  // NOTE: every state and output register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      breq      <= 1'b0;
      haddr     <= '0;
      hwdata    <= '0;
      hmas      <= NO_MASTER;
      mlock     <= 1'b0;
      c_write   <= 1'b0;
      c_slv     <= '0;
      c_addr    <= '0;
      c_wdata   <= '0;
      c_lock    <= 1'b0;
      retry_cnt <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            c_write   <= req_write;
            c_slv     <= req_slv;
            c_addr    <= req_addr;
            c_wdata   <= req_wdata;
            c_lock    <= req_lock;
            retry_cnt <= '0;
            breq      <= 1'b1;
            req_ready <= 1'b0;
            state     <= ST_REQ;
          end else begin
            // Ready returns one cycle after the response pulse.
            req_ready <= 1'b1;
          end
        end
        ST_REQ: begin
          breq <= 1'b1;
          if (bgnt) begin
            haddr <= make_haddr(1'b0, c_slv, c_write, c_addr);
            hmas  <= MASTER_ID;
            mlock <= c_lock;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          haddr  <= make_haddr(1'b1, c_slv, c_write, c_addr);
          hwdata <= c_write ? c_wdata : '0;
`ifdef BUS_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state  <= ST_DATA;
        end
        ST_DATA: begin
          if (hready) begin
            haddr  <= '0;
            hwdata <= '0;
            hmas   <= NO_MASTER;
            mlock  <= 1'b0;
            unique case (resp_e'(hresp))
              RESP_OKAY: begin
                if (!c_write) rsp_rdata <= hrdata;
                rsp_valid <= 1'b1;
                breq      <= 1'b0;
                state     <= ST_IDLE;
              end
              RESP_ERROR: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                breq      <= 1'b0;
                state     <= ST_IDLE;
              end
              RESP_RETRY: begin
                if (retry_cnt == RW'(MAX_RETRY - 1)) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  breq      <= 1'b0;
                  state     <= ST_IDLE;
                end else begin
                  retry_cnt <= retry_cnt + 1'b1;
                  state     <= ST_REQ;
                end
              end
              RESP_SPLIT: begin
                breq  <= 1'b0;
                state <= ST_SPLIT_WAIT;
              end
            endcase
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            haddr     <= '0;
            hwdata    <= '0;
            hmas      <= NO_MASTER;
            mlock     <= 1'b0;
            breq      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_SPLIT_WAIT: begin
          // Only a release naming this master resumes; the command is reissued unchanged.
          if (hsplit == MASTER_ID) begin
            breq  <= 1'b1;
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_split.sv
// Randomized self-checking bench for bus_master_split: the bench plays arbiter and slave and
// predicts each command's outcome from the bus protocol rules at transaction level.
module tb_bus_master_split;
  import bus_pkg::*;

  localparam logic [1:0] MID  = 2'b01;
  localparam int         MAXR = 4;
  localparam int         TMO  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_lock;
  logic [1:0]  req_slv;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        breq, bgnt;
  logic [15:0] haddr;
  logic [31:0] hwdata, hrdata;
  logic [1:0]  hmas, hresp, hsplit;
  logic        mlock, hready;

  bus_master_split #(.MASTER_ID(MID), .MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_slv(req_slv), .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .breq(breq), .bgnt(bgnt), .haddr(haddr), .hwdata(hwdata), .hmas(hmas), .mlock(mlock),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .hsplit(hsplit)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rdata;
  int          plan_wait[$];
  logic [1:0]  plan_resp[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] slv, input logic [11:0] addr,
                       input logic [31:0] wd, input logic lk);
    int b = 0;
    while (!req_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_slv   = slv;
    req_addr  = addr;
    req_wdata = wd;
    req_lock  = lk;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = $urandom_range(0, 1);
    req_slv   = 2'($urandom);
    req_addr  = 12'($urandom);
    req_wdata = $urandom;
    req_lock  = $urandom_range(0, 1);
  endtask

  // Runs one command to completion, acting as arbiter and slave; expectations come from the rules.
  task automatic run_cmd(input logic wr, input logic [1:0] slv, input logic [11:0] addr,
                         input logic [31:0] wd, input logic lk, input bit grant_always,
                         output int latency, output int attempts);
    logic [15:0] exp_a = {1'b0, slv, wr, addr};
    int          retries = 0, waits_left = 0, split_k = 0, k = 0;
    bit          expect_rsp = 0, exp_err = 0, in_split = 0, done = 0;
    logic [1:0]  resp_sel = RESP_OKAY;
    logic [31:0] rd_sel = '0;
    latency  = 0;
    attempts = 0;
    issue(wr, slv, addr, wd, lk);
    while (!done && k < 400) begin
      if (expect_rsp) begin
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, last_rdata);
        check("breq_at_rsp", breq, 1'b0);
        check("hmas_at_rsp", hmas, NO_MASTER);
        latency = k + 1;
        done = 1;
      end else begin
        if (rsp_valid) check("rsp_early", rsp_valid, 1'b0);
        if (in_split) begin
          split_k++;
          case (split_k)
            1: begin
              check("split_breq", breq, 1'b0);
              check("split_hmas", hmas, NO_MASTER);
              check("split_haddr", haddr, 16'h0000);
              hsplit = 2'd2;
            end
            2: begin
              check("split_other_id", breq, 1'b0);
              hsplit = MID;
            end
            default: begin
              check("split_resume", breq, 1'b1);
              hsplit = 2'd0;
              in_split = 0;
            end
          endcase
        end
        if (hmas == MID && !haddr[15]) begin
          check("haddr_addr", haddr, exp_a);
          check("mlock", mlock, lk);
          attempts++;
          if (plan_resp.size() > 0) begin
            resp_sel   = plan_resp.pop_front();
            waits_left = plan_wait.pop_front();
          end else begin
            int r = $urandom_range(0, 99);
            resp_sel   = (r < 40) ? RESP_OKAY : (r < 55) ? RESP_ERROR :
                         (r < 85) ? RESP_RETRY : RESP_SPLIT;
            waits_left = $urandom_range(0, 3);
          end
          rd_sel = $urandom;
          hready = 1'b0;
        end else if (hmas == MID && haddr[15]) begin
          check("haddr_data", haddr, exp_a | 16'h8000);
          if (wr) check("hwdata", hwdata, wd);
          if (waits_left > 0) begin
            waits_left--;
            hready = 1'b0;
            hrdata = $urandom;
          end else begin
            hready = 1'b1;
            hresp  = resp_sel;
            hrdata = rd_sel;
            if (resp_sel == RESP_OKAY) begin
              expect_rsp = 1; exp_err = 0;
              if (!wr) last_rdata = rd_sel;
            end else if (resp_sel == RESP_ERROR) begin
              expect_rsp = 1; exp_err = 1;
            end else if (resp_sel == RESP_RETRY) begin
              retries++;
              if (retries == MAXR) begin expect_rsp = 1; exp_err = 1; end
            end else begin
              in_split = 1; split_k = 0;
            end
          end
        end else begin
          hready = 1'b0;
          hresp  = RESP_OKAY;
        end
      end
      if (!done) begin
        bgnt = grant_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        @(negedge clk);
        k++;
      end
    end
    if (!done) check("cmd_no_response", 1'b0, 1'b1);
    hready = 1'b0;
    hsplit = 2'd0;
    @(negedge clk);
    check("req_ready_after_rsp", req_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_err"},   rsp_err, 1'b0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_breq"},      breq, 1'b0);
    check({tag, "_haddr"},     haddr, 16'h0);
    check({tag, "_hwdata"},    hwdata, 32'h0);
    check({tag, "_hmas"},      hmas, NO_MASTER);
    check({tag, "_mlock"},     mlock, 1'b0);
  endtask

  task automatic wait_data_phase(input string tag);
    int b = 0;
    while (!(hmas == MID && haddr[15]) && b < 50) begin
      @(negedge clk);
      b++;
    end
    check(tag, haddr[15], 1'b1);
  endtask

  initial begin
    int lat, att, n;
    bit seen;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_slv = '0; req_addr = '0;
    req_wdata = '0; req_lock = 1'b0; bgnt = 1'b0; hrdata = '0; hready = 1'b0;
    hresp = RESP_OKAY; hsplit = 2'd0;
    last_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Zero-wait write, grant already high.
    bgnt = 1'b1;
    plan_resp.push_back(RESP_OKAY); plan_wait.push_back(0);
    run_cmd(1'b1, 2'd1, 12'h003, 32'h12153524, 1'b0, 1'b1, lat, att);
    check("write_latency", lat, 4);

    // Read with three wait states.
    plan_resp.push_back(RESP_OKAY); plan_wait.push_back(3);
    run_cmd(1'b0, 2'd1, 12'h003, 32'h0, 1'b1, 1'b1, lat, att);
    check("read_latency", lat, 7);

    // Split then resume and complete.
    plan_resp.push_back(RESP_SPLIT); plan_wait.push_back(0);
    plan_resp.push_back(RESP_OKAY);  plan_wait.push_back(1);
    run_cmd(1'b0, 2'd1, 12'h003, 32'h0, 1'b0, 1'b1, lat, att);
    check("split_attempts", att, 2);

    // Retry limit.
    repeat (MAXR) begin plan_resp.push_back(RESP_RETRY); plan_wait.push_back(0); end
    run_cmd(1'b1, 2'd2, 12'hFFF, 32'hA5A5_5A5A, 1'b1, 1'b1, lat, att);
    check("retry_attempts", att, MAXR);

    // Error response.
    plan_resp.push_back(RESP_ERROR); plan_wait.push_back(2);
    run_cmd(1'b0, 2'd3, 12'h000, 32'h0, 1'b0, 1'b1, lat, att);

    // Randomized commands with random grant and slave behaviour.
    for (int i = 0; i < 40; i++) begin
      run_cmd($urandom_range(0, 1), 2'($urandom), 12'($urandom), $urandom,
              $urandom_range(0, 1), 1'b0, lat, att);
    end

    // Reset while in DATA abandons the command silently.
    bgnt = 1'b1;
    issue(1'b1, 2'd1, 12'h055, 32'hCAFE_F00D, 1'b1);
    wait_data_phase("reach_data_for_reset");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rdata = '0;
    check_reset_outputs("midreset");
    @(negedge clk);
    check("midreset_no_rsp", rsp_valid, 1'b0);

    // DATA phase with HREADY held low.
    issue(1'b0, 2'd2, 12'h123, 32'h0, 1'b0);
    wait_data_phase("reach_data_for_timeout");
    hready = 1'b0;
`ifdef BUS_TIMEOUT_EN
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_err", rsp_err, 1'b1);
    check("timeout_breq", breq, 1'b0);
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("no_timeout_rsp", seen, 1'b0);
    check("no_timeout_in_data", haddr[15], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
